wave_meter: RTL and testbench
=============================

# wave_meter

Measures the waveform produced by the function generator: consumes the sampled wave stream (one sample per wave-clock strobe), detects rising mid-level crossings with hysteresis, and reports period in samples plus peak, trough and peak-to-peak amplitude of each complete cycle. It sits at the observing end of the generator output and is used for self-check and display of the selected wave/frequency/amplitude.

## Interface

- DW, 8: sample width, unsigned samples.
- CW, 16: period counter width.
- HYST, 4: hysteresis half-width; must satisfy 0 < HYST < 2^(DW-1).

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe (wave-clock enable); sample is valid only when en=1.
- sample  in  DW  unsigned wave sample.
- period  out  CW  samples in last complete cycle.
- peak  out  DW  maximum sample of last cycle.
- trough  out  DW  minimum sample of last cycle.
- amp  out  DW  peak - trough of last cycle.
- valid  out  1  one-clock pulse: new result on period/peak/trough/amp.
- ovf  out  1  sticky: period counter saturated at least once since reset.

## Operation

- Thresholds: MID = 2^(DW-1); HI = MID+HYST; LO = MID-HYST. "High" = sample >= HI; "low" = sample < LO; between is neutral (no state change).
- Only cycles with en=1 affect state; en=0 cycles hold everything (valid=0).
- FSM states:
  - SEEK (reset state): on low sample -> ARM.
  - ARM: on high sample -> HIGH; cnt<=1, max<=min<=sample.
  - HIGH: each sample: cnt++, max/min update; on low sample -> LOW.
  - LOW: each non-high sample: cnt++, max/min update. On high sample (rising crossing): period<=cnt, peak<=max, trough<=min, amp<=max-min, valid pulse; then cnt<=1, max<=min<=sample; -> HIGH.
- The crossing sample belongs to the new cycle, not the reported one. First rising crossing after reset only starts measurement; first valid comes on the second.
- cnt is CW bits, saturating: when cnt = 2^CW-1 and an increment is due, cnt holds and ovf<=1. A saturated cycle reports period = 2^CW-1. ovf clears only on rst.
- amp computed from registered max/min, DW bits, never negative (max >= min by construction).
- Result registers hold last values until the next crossing.

## Timing

- rst asserted (any time, asynchronous): state=SEEK, cnt=0, max=min=0, period=peak=trough=amp=0, valid=0, ovf=0. Reset mid-cycle discards the partial measurement; measurement restarts from SEEK.
- Latency: the clock edge that samples a crossing (en=1, sample high, state LOW) updates all result outputs and raises valid; valid is high for exactly that following clock period and drops at the next edge.
- All outputs registered; no combinational path from inputs to outputs.
- Back-to-back: en every clock supported; minimum reportable period is 2 samples (one high, one low).
- Saturation and crossing on the same sample: crossing wins — reports period = 2^CW-1, restarts cnt=1; ovf still set if that increment was due.

## Test plan

- Reset: drive random samples with rst=1 -> all outputs 0, valid never 1; release, apply one high sample only -> no valid.
- Square wave 10x255 / 10x0, en every clock -> first valid at second rising crossing; period=20, peak=255, trough=0, amp=255; valid repeats every 20 clocks.
- Sawtooth 0,16,...,240 repeating, en every clock -> period=16, peak=240, trough=0, amp=240.
- Noise in hysteresis band: alternate 126/130 for 200 samples after arming -> no valid, no state change; then resume square wave -> results correct.
- Same square wave with en every 3rd clock, sample changing only on strobe -> period=20 (samples, not clocks), valid spacing 60 clocks.
- CW=8: arm, cross high, hold 255 for 300 samples, then low then high -> ovf=1 and reported period=255; pulse rst mid-cycle -> outputs 0, ovf cleared.

Source files
------------

// File: rtl/wave_meter.sv
// rtl/wave_meter.sv - wave period and amplitude meter using mid-level crossings with hysteresis
module wave_meter #(
  parameter int DW   = 8,
  parameter int CW   = 16,
  parameter int HYST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] sample,
  output logic [CW-1:0] period,
  output logic [DW-1:0] peak,
  output logic [DW-1:0] trough,
  output logic [DW-1:0] amp,
  output logic          valid,
  output logic          ovf
);

  localparam logic [DW-1:0] MID     = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] HI      = MID + DW'(HYST);
  localparam logic [DW-1:0] LO      = MID - DW'(HYST);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEEK, ARM, HIGH, LOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] max_q, max_d;
  logic [DW-1:0] min_q, min_d;
  logic [CW-1:0] period_q, period_d;
  logic [DW-1:0] peak_q, peak_d;
  logic [DW-1:0] trough_q, trough_d;
  logic [DW-1:0] amp_q, amp_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;

  logic is_high, is_low;
  logic [CW-1:0] cnt_inc;
  logic          cnt_sat;
  logic [DW-1:0] max_upd, min_upd;

  assign is_high = (sample >= HI);
  assign is_low  = (sample < LO);
  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CW'(1);
  assign max_upd = (sample > max_q) ? sample : max_q;
  assign min_upd = (sample < min_q) ? sample : min_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    min_d    = min_q;
    period_d = period_q;
    peak_d   = peak_q;
    trough_d = trough_q;
    amp_d    = amp_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    if (en) begin
      case (state_q)
        SEEK: begin
          if (is_low) state_d = ARM;
        end
        ARM: begin
          if (is_high) begin
            state_d = HIGH;
            cnt_d   = CW'(1);
            max_d   = sample;
            min_d   = sample;
          end
        end
        HIGH: begin
          cnt_d = cnt_inc;
          ovf_d = ovf_q | cnt_sat;
          max_d = max_upd;
          min_d = min_upd;
          if (is_low) state_d = LOW;
        end
        LOW: begin
          if (is_high) begin
            // Crossing sample opens the next cycle; it is not part of the reported one.
            period_d = cnt_q;
            peak_d   = max_q;
            trough_d = min_q;
            amp_d    = max_q - min_q;
            valid_d  = 1'b1;
            cnt_d    = CW'(1);
            max_d    = sample;
            min_d    = sample;
            state_d  = HIGH;
          end else begin
            cnt_d = cnt_inc;
            ovf_d = ovf_q | cnt_sat;
            max_d = max_upd;
            min_d = min_upd;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEEK;
      cnt_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      period_q <= '0;
      peak_q   <= '0;
      trough_q <= '0;
      amp_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      min_q    <= min_d;
      period_q <= period_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      amp_q    <= amp_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period = period_q;
  assign peak   = peak_q;
  assign trough = trough_q;
  assign amp    = amp_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_wave_meter.sv
// tb/tb_wave_meter.sv - directed self-checking bench for wave_meter (CW=16 and CW=8 instances)
module tb_wave_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  sample = 8'd0;
  logic [15:0] period;
  logic [7:0]  peak, trough, amp;
  logic        valid, ovf;

  logic        rst8 = 1'b1;
  logic        en8 = 1'b0;
  logic [7:0]  sample8 = 8'd0;
  logic [7:0]  period8, peak8, trough8, amp8;
  logic        valid8, ovf8;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wave_meter #(.DW(8), .CW(16), .HYST(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sample(sample),
    .period(period), .peak(peak), .trough(trough), .amp(amp),
    .valid(valid), .ovf(ovf)
  );

  wave_meter #(.DW(8), .CW(8), .HYST(4)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .sample(sample8),
    .period(period8), .peak(peak8), .trough(trough8), .amp(amp8),
    .valid(valid8), .ovf(ovf8)
  );

  task automatic drive(input logic e, input logic [7:0] s);
    @(negedge clk);
    en = e;
    sample = s;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic e, input logic [7:0] s);
    @(negedge clk);
    en8 = e;
    sample8 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] s;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s = 8'($urandom_range(0, 255));
      drive(1'b1, s);
      n_chk++;
      if ({period, peak, trough, amp, valid, ovf} !== 42'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got p=%0d pk=%0d tr=%0d a=%0d v=%b o=%b, want all 0",
                 i, period, peak, trough, amp, valid, ovf);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'd255);
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_one_high: valid=%b want 0", valid);
    end
    drive(1'b1, 8'd0);
    drive(1'b1, 8'd255);
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_crossing: valid=%b want 0", valid);
    end
  endtask

  task automatic test_square();
    logic [7:0] s;
    logic exp_v;
    int nv = 0;
    do_reset();
    for (int k = 0; k < 90; k++) begin
      s = (((k / 10) % 2) == 1) ? 8'd255 : 8'd0;
      drive(1'b1, s);
      exp_v = (k >= 30) && (((k - 10) % 20) == 0);
      n_chk++;
      if (valid !== exp_v) begin
        n_fail++;
        $display("FAIL square_valid k=%0d: valid=%b want %b", k, valid, exp_v);
      end
      if (exp_v) begin
        nv++;
        n_chk++;
        if (period !== 16'd20 || peak !== 8'd255 || trough !== 8'd0 || amp !== 8'd255) begin
          n_fail++;
          $display("FAIL square_result k=%0d: p=%0d pk=%0d tr=%0d a=%0d want 20/255/0/255",
                   k, period, peak, trough, amp);
        end
      end
    end
    n_chk++;
    if (nv != 3) begin
      n_fail++;
      $display("FAIL square_count: got %0d valids want 3", nv);
    end
  endtask

  task automatic test_sawtooth();
    logic [7:0] s;
    logic exp_v;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      s = 8'((k % 16) * 16);
      drive(1'b1, s);
      exp_v = (k >= 25) && (((k - 9) % 16) == 0);
      n_chk++;
      if (valid !== exp_v) begin
        n_fail++;
        $display("FAIL saw_valid k=%0d: valid=%b want %b", k, valid, exp_v);
      end
      if (exp_v) begin
        n_chk++;
        if (period !== 16'd16 || peak !== 8'd240 || trough !== 8'd0 || amp !== 8'd240) begin
          n_fail++;
          $display("FAIL saw_result k=%0d: p=%0d pk=%0d tr=%0d a=%0d want 16/240/0/240",
                   k, period, peak, trough, amp);
        end
      end
    end
  endtask

  task automatic test_noise();
    logic [7:0] s;
    logic exp_v;
    do_reset();
    for (int k = 0; k < 10; k++) drive(1'b1, 8'd0);
    for (int i = 0; i < 200; i++) begin
      s = ((i % 2) == 1) ? 8'd130 : 8'd126;
      drive(1'b1, s);
      n_chk++;
      if (valid !== 1'b0 || period !== 16'd0) begin
        n_fail++;
        $display("FAIL noise_band i=%0d: valid=%b period=%0d want 0/0", i, valid, period);
      end
    end
    // Still armed, so the first high sample only opens a cycle.
    for (int k = 0; k < 60; k++) begin
      s = (((k / 10) % 2) == 1) ? 8'd0 : 8'd255;
      drive(1'b1, s);
      exp_v = (k > 0) && ((k % 20) == 0);
      n_chk++;
      if (valid !== exp_v) begin
        n_fail++;
        $display("FAIL noise_resume_valid k=%0d: valid=%b want %b", k, valid, exp_v);
      end
      if (exp_v) begin
        n_chk++;
        if (period !== 16'd20 || peak !== 8'd255 || trough !== 8'd0 || amp !== 8'd255) begin
          n_fail++;
          $display("FAIL noise_resume_result k=%0d: p=%0d pk=%0d tr=%0d a=%0d want 20/255/0/255",
                   k, period, peak, trough, amp);
        end
      end
    end
  endtask

  task automatic test_strobe3();
    logic [7:0] s;
    logic exp_v;
    int clk_i = 0;
    int last_v = -1;
    int nv = 0;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      s = (((k / 10) % 2) == 1) ? 8'd255 : 8'd0;
      drive(1'b1, s);
      clk_i++;
      exp_v = (k >= 30) && (((k - 10) % 20) == 0);
      n_chk++;
      if (valid !== exp_v) begin
        n_fail++;
        $display("FAIL strobe_valid k=%0d: valid=%b want %b", k, valid, exp_v);
      end
      if (valid === 1'b1) begin
        nv++;
        n_chk++;
        if (period !== 16'd20 || amp !== 8'd255) begin
          n_fail++;
          $display("FAIL strobe_result k=%0d: p=%0d a=%0d want 20/255", k, period, amp);
        end
        if (last_v >= 0) begin
          n_chk++;
          if (clk_i - last_v != 60) begin
            n_fail++;
            $display("FAIL strobe_spacing: got %0d clocks want 60", clk_i - last_v);
          end
        end
        last_v = clk_i;
      end
      for (int j = 0; j < 2; j++) begin
        drive(1'b0, s);
        clk_i++;
        n_chk++;
        if (valid !== 1'b0) begin
          n_fail++;
          $display("FAIL strobe_idle k=%0d: valid=%b want 0", k, valid);
        end
      end
    end
    n_chk++;
    if (nv != 2) begin
      n_fail++;
      $display("FAIL strobe_count: got %0d valids want 2", nv);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    logic exp_v;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      s = ((k % 2) == 1) ? 8'd255 : 8'd0;
      drive(1'b1, s);
      exp_v = (k >= 3) && ((k % 2) == 1);
      n_chk++;
      if (valid !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_valid k=%0d: valid=%b want %b", k, valid, exp_v);
      end
      if (exp_v) begin
        n_chk++;
        if (period !== 16'd2 || peak !== 8'd255 || trough !== 8'd0 || amp !== 8'd255) begin
          n_fail++;
          $display("FAIL b2b_result k=%0d: p=%0d pk=%0d tr=%0d a=%0d want 2/255/0/255",
                   k, period, peak, trough, amp);
        end
      end
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    rst8 = 1'b0;
    drive8(1'b1, 8'd0);
    drive8(1'b1, 8'd255);
    for (int i = 0; i < 300; i++) begin
      drive8(1'b1, 8'd255);
      if (i == 100) begin
        n_chk++;
        if (ovf8 !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_ovf_early: ovf=%b want 0", ovf8);
        end
      end
    end
    n_chk++;
    if (ovf8 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_ovf_set: ovf=%b want 1", ovf8);
    end
    drive8(1'b1, 8'd0);
    drive8(1'b1, 8'd255);
    n_chk++;
    if (valid8 !== 1'b1 || period8 !== 8'd255 || peak8 !== 8'd255 || trough8 !== 8'd0 ||
        amp8 !== 8'd255 || ovf8 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_result: v=%b p=%0d pk=%0d tr=%0d a=%0d o=%b want 1/255/255/0/255/1",
               valid8, period8, peak8, trough8, amp8, ovf8);
    end
    drive8(1'b1, 8'd255);
    drive8(1'b1, 8'd0);
    @(negedge clk);
    #2;
    rst8 = 1'b1;
    #1;
    n_chk++;
    if ({period8, peak8, trough8, amp8, valid8, ovf8} !== 34'd0) begin
      n_fail++;
      $display("FAIL sat_async_reset: p=%0d pk=%0d tr=%0d a=%0d v=%b o=%b want all 0",
               period8, peak8, trough8, amp8, valid8, ovf8);
    end
    @(negedge clk);
    rst8 = 1'b0;
    drive8(1'b1, 8'd255);
    drive8(1'b1, 8'd0);
    drive8(1'b1, 8'd255);
    drive8(1'b1, 8'd0);
    drive8(1'b1, 8'd255);
    n_chk++;
    if (valid8 !== 1'b1 || period8 !== 8'd2 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_restart: v=%b p=%0d o=%b want 1/2/0", valid8, period8, ovf8);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_sawtooth();
    test_noise();
    test_strobe3();
    test_back_to_back();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
